// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns the divider's slow tick into single-clk CPU enables.
// Supports free-run, debounced single-step and halt, all on the one system clock.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] en_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            tick_q_reg;
    logic            run_m_reg, run_s_reg;
    logic            btn_m_reg, btn_s_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic            db_level_reg;
    logic            step_req_reg;
    logic            tick_pulse;

    state_t          state_reg, state_next;
    logic            cpu_en_reg, cpu_en_next;
    logic            halted_reg;
    logic [CNT_W-1:0] en_count_reg;

    assign tick_pulse = tick_in & ~tick_q_reg;

    // Input conditioning: tick edge detect, synchronizers and button debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q_reg   <= 1'b0;
            run_m_reg    <= 1'b0;
            run_s_reg    <= 1'b0;
            btn_m_reg    <= 1'b0;
            btn_s_reg    <= 1'b0;
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
            step_req_reg <= 1'b0;
        end else begin
            tick_q_reg   <= tick_in;
            run_m_reg    <= run_sw;
            run_s_reg    <= run_m_reg;
            btn_m_reg    <= step_btn;
            btn_s_reg    <= btn_m_reg;
            step_req_reg <= 1'b0;
            if (btn_s_reg == db_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_level_reg <= btn_s_reg;
                db_cnt_reg   <= '0;
                // Only the press edge requests a step; release is swallowed here.
                step_req_reg <= btn_s_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cpu_en_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (halt_in)           state_next = HALT;
                else if (run_s_reg)    state_next = RUN;
                else if (step_req_reg) state_next = STEP;
            end
            RUN: begin
                if (halt_in)         state_next = HALT;
                else if (!run_s_reg) state_next = IDLE;
                else                 cpu_en_next = tick_pulse;
            end
            STEP: begin
                if (halt_in) begin
                    state_next = HALT;
                end else if (tick_pulse) begin
                    cpu_en_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            HALT: begin
                if (!halt_in && !run_s_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cpu_en_reg   <= 1'b0;
            halted_reg   <= 1'b0;
            en_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cpu_en_reg <= cpu_en_next;
            halted_reg <= (state_next == HALT);
            // Counter moves on the same edge as the pulse so it already includes it.
            if (cpu_en_next) en_count_reg <= en_count_reg + 1'b1;
        end
    end

    assign cpu_en   = cpu_en_reg;
    assign state    = state_reg;
    assign halted   = halted_reg;
    assign en_count = en_count_reg;

endmodule
